// File: rtl/pwm_output_stage_if.sv
// pwm_output_stage_if: bundles the enable/mode/duty controls and the PWM
// output pins of pwm_output_stage.
// There is no valid/ready handshake on this bus. The master holds the
// control fields as plain levels, synchronous to clk. The stage samples
// them on every rising edge. out and period_start are registered outputs
// of the slave.
interface pwm_output_stage_if;
    logic [7:0]  en_out_7_0;
    logic [7:0]  en_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_out_7_0, en_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out, period_start
    );

    modport slave (
        input  en_out_7_0, en_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out, period_start
    );
endinterface

// File: rtl/pwm_output_stage.sv
// pwm_output_stage: 16-channel PWM / static-high output stage.
// A prescaler divides clk by CLK_DIV to step an 8-bit period counter.
// Each channel is either off, static high, or PWM against the shared duty.
//
// Optional feature macro: PWM_SHADOW_EN
//   When defined, the enable, mode and duty inputs are captured into shadow
//   registers only at the 255->0 wrap. Changes therefore land on period
//   boundaries.
//   When undefined, the inputs drive the compare logic directly.
module pwm_output_stage #(
    parameter int CLK_DIV = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_output_stage_if.slave    bus
);

    logic [7:0]  presc;
    logic [7:0]  cnt;
    logic        tick;
    logic        wrap;
    logic [15:0] eff_en;
    logic [15:0] eff_pwm;
    logic [7:0]  eff_duty;
    logic        pwm_on;
    logic [15:0] out_next;

    assign tick = (presc == 8'(CLK_DIV - 1));
    assign wrap = tick && (cnt == 8'hFF);

    // Prescaler: counts 0..CLK_DIV-1 and restarts on tick.
    always_ff @(posedge clk) begin
        if (rst)       presc <= 8'd0;
        else if (tick) presc <= 8'd0;
        else           presc <= presc + 8'd1;
    end

    // Period counter: one step per tick, natural 8-bit wrap 255->0.
    always_ff @(posedge clk) begin
        if (rst)       cnt <= 8'd0;
        else if (tick) cnt <= cnt + 8'd1;
    end

`ifdef PWM_SHADOW_EN
    logic [15:0] sh_en;
    logic [15:0] sh_pwm;
    logic [7:0]  sh_duty;

    // Shadow load only at the period wrap, so a running period is never altered.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_en   <= 16'h0000;
            sh_pwm  <= 16'h0000;
            sh_duty <= 8'h00;
        end else if (wrap) begin
            sh_en   <= {bus.en_out_15_8, bus.en_out_7_0};
            sh_pwm  <= {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
            sh_duty <= bus.pwm_duty_cycle;
        end
    end

    assign eff_en   = sh_en;
    assign eff_pwm  = sh_pwm;
    assign eff_duty = sh_duty;
`else
    assign eff_en   = {bus.en_out_15_8, bus.en_out_7_0};
    assign eff_pwm  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    assign eff_duty = bus.pwm_duty_cycle;
`endif

    // Compare: duty 0xFF is forced fully on so the last step never drops low.
    always_comb begin
        pwm_on   = (cnt < eff_duty) || (eff_duty == 8'hFF);
        out_next = eff_en & (~eff_pwm | {16{pwm_on}});
    end

    // Output register. period_start marks the first cycle with cnt == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out          <= 16'h0000;
            bus.period_start <= 1'b0;
        end else begin
            bus.out          <= out_next;
            bus.period_start <= wrap;
        end
    end

endmodule
